// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding and constant helpers for the packet router FSM
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    WAIT_TILL_EMPTY    = 4'd2,
    LOAD_DATA          = 4'd3,
    LOAD_PARITY        = 4'd4,
    FIFO_FULL_STATE    = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_fsm_mc_if.sv
// rtl/router_fsm_mc_if.sv - packet-source, FIFO-status and state-decode bundle of the router FSM
interface router_fsm_mc_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] fifo_empty;
  logic              fifo_full;

  logic              busy;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              drop_state;
  logic [NUM_CH-1:0] dest_sel;
  logic              wait_timeout;
  logic              len_err;

  modport master (
    output pkt_valid, parity_done, low_pkt_valid, data_in, soft_reset, fifo_empty, fifo_full,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, drop_state, dest_sel, wait_timeout, len_err
  );

  modport slave (
    input  pkt_valid, parity_done, low_pkt_valid, data_in, soft_reset, fifo_empty, fifo_full,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, drop_state, dest_sel, wait_timeout, len_err
  );
endinterface

// File: rtl/router_dest_dec.sv
// rtl/router_dest_dec.sv - header address to one-hot channel select with range check
module router_dest_dec #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NUM_CH-1:0] o_onehot,
  output logic              o_valid
);

  // Out-of-range addresses decode to all-zero, which the FSM relies on for drops.
  assign o_valid = int'(i_addr) < NUM_CH;

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(i_addr) == i) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/router_fsm_mc.sv
// rtl/router_fsm_mc.sv - router write-side FSM: destination select, wait/drop, full handling, length check
module router_fsm_mc
  import router_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32,
  parameter int MAX_LEN      = 63
) (
  input logic           clock,
  input logic           resetn,
  router_fsm_mc_if.slave bus
);

  localparam int WC_W = clog2(WAIT_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [NUM_CH-1:0] r_dest_sel;
  logic [NUM_CH-1:0] w_dec_onehot;
  logic              w_addr_ok;
  logic              w_addr_empty;
  logic              w_sel_empty;
  logic              w_rst;
  logic              w_timeout;
  logic              w_beat_inc;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [7:0]        r_beat_cnt;
  logic [7:0]        w_beat_nxt;
  logic              r_len_err;

  router_dest_dec #(
    .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W)
  ) u_dest_dec (
    .i_addr  (bus.data_in),
    .o_onehot(w_dec_onehot),
    .o_valid (w_addr_ok)
  );

  // A soft reset only counts when it hits the channel this packet is headed for.
  assign w_rst        = !resetn || (|(bus.soft_reset & r_dest_sel));
  assign w_addr_empty = |(bus.fifo_empty & w_dec_onehot);
  assign w_sel_empty  = |(bus.fifo_empty & r_dest_sel);
  assign w_timeout    = (r_state == WAIT_TILL_EMPTY) && !w_sel_empty &&
                        (r_wait_cnt == WC_W'(WAIT_TIMEOUT - 1));
  assign w_beat_inc   = (r_state == LOAD_DATA) || (r_state == LOAD_AFTER_FULL);
  assign w_beat_nxt   = (w_beat_inc && (r_beat_cnt != 8'hFF)) ? r_beat_cnt + 8'd1 : r_beat_cnt;

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_state    <= DECODE_ADDRESS;
      r_dest_sel <= '0;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == DECODE_ADDRESS) && bus.pkt_valid) r_dest_sel <= w_dec_onehot;
      r_wait_cnt <= ((r_state == WAIT_TILL_EMPTY) && (w_next == WAIT_TILL_EMPTY)) ?
                    r_wait_cnt + WC_W'(1) : '0;
      if (w_next == DECODE_ADDRESS) begin
        r_beat_cnt <= '0;
        r_len_err  <= 1'b0;
      end else begin
        r_beat_cnt <= w_beat_nxt;
        if (int'(w_beat_nxt) > MAX_LEN) r_len_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next            = DECODE_ADDRESS;
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.drop_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b1;
    case (r_state)
      DECODE_ADDRESS: begin
        bus.detect_add = 1'b1;
        bus.busy       = 1'b0;
        if (!bus.pkt_valid)   w_next = DECODE_ADDRESS;
        else if (!w_addr_ok)  w_next = DROP_PACKET;
        else if (w_addr_empty) w_next = LOAD_FIRST_DATA;
        else                  w_next = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: begin
        bus.lfd_state = 1'b1;
        w_next        = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (w_sel_empty)    w_next = LOAD_FIRST_DATA;
        else if (w_timeout) w_next = DROP_PACKET;
        else                w_next = WAIT_TILL_EMPTY;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b0;
        if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_next = LOAD_PARITY;
        else                     w_next = LOAD_DATA;
      end
      LOAD_PARITY: begin
        bus.write_enb_reg = 1'b1;
        w_next            = CHECK_PARITY_ERROR;
      end
      FIFO_FULL_STATE: begin
        bus.full_state = 1'b1;
        w_next         = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      end
      CHECK_PARITY_ERROR: begin
        bus.rst_int_reg = 1'b1;
        w_next          = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      LOAD_AFTER_FULL: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        if (bus.parity_done)        w_next = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
        else                        w_next = LOAD_DATA;
      end
      DROP_PACKET: begin
        bus.drop_state = 1'b1;
        w_next         = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
      end
      default: w_next = DECODE_ADDRESS;
    endcase
  end

  assign bus.dest_sel     = r_dest_sel;
  assign bus.wait_timeout = w_timeout;
  assign bus.len_err      = r_len_err;

endmodule

// File: tb/tb_router_fsm_mc.sv
// tb/tb_router_fsm_mc.sv - scoreboard bench for router_fsm_mc (NUM_CH=3, WAIT_TIMEOUT=4, MAX_LEN=2)
module tb_router_fsm_mc;
  import router_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;

  logic clock;
  logic resetn;
  int   n_vec;
  int   n_miss;

  typedef struct {
    string      tag;
    logic [8:0] dec;
    logic [2:0] dest;
    logic [1:0] flg;
  } exp_t;

  exp_t sb_q[$];

  router_fsm_mc_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  router_fsm_mc #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .WAIT_TIMEOUT(4),
    .MAX_LEN     (2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Decode order: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop}
  function automatic logic [8:0] dec_of(input state_t s);
    case (s)
      DECODE_ADDRESS:     return 9'b010000000;
      LOAD_FIRST_DATA:    return 9'b101000000;
      WAIT_TILL_EMPTY:    return 9'b100000000;
      LOAD_DATA:          return 9'b000100100;
      LOAD_PARITY:        return 9'b100000100;
      FIFO_FULL_STATE:    return 9'b100001000;
      CHECK_PARITY_ERROR: return 9'b100000010;
      LOAD_AFTER_FULL:    return 9'b100010100;
      DROP_PACKET:        return 9'b100000001;
      default:            return 9'b100000000;
    endcase
  endfunction

  // Drive one cycle of inputs, record what the DUT must show now, then compare.
  task automatic cyc(input string tag, input logic rn, input logic pv, input logic [1:0] addr,
                     input logic [2:0] fe, input logic ff, input logic pd, input logic lpv,
                     input logic [2:0] sr, input state_t est, input logic [2:0] edest,
                     input logic ewt, input logic ele);
    exp_t e;
    @(negedge clock);
    resetn            = rn;
    bus.pkt_valid     = pv;
    bus.data_in       = addr;
    bus.fifo_empty    = fe;
    bus.fifo_full     = ff;
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
    bus.soft_reset    = sr;
    e.tag  = tag;
    e.dec  = dec_of(est);
    e.dest = edest;
    e.flg  = {ewt, ele};
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".dec"}, 32'({bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                              bus.laf_state, bus.full_state, bus.write_enb_reg,
                              bus.rst_int_reg, bus.drop_state}), 32'(e.dec));
    chk({e.tag, ".dest"}, 32'(bus.dest_sel), 32'(e.dest));
    chk({e.tag, ".flg"}, 32'({bus.wait_timeout, bus.len_err}), 32'(e.flg));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    resetn = 1'b0;
    bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_empty = '0; bus.fifo_full = 1'b0;
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0; bus.soft_reset = '0;

    //   tag         rn pv addr fe      ff pd lpv sr      state               dest    wt ele
    cyc("rst",       0, 0, 0, 3'b000, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);

    // Four-beat packet to channel 1 (len_err also trips since MAX_LEN=2)
    cyc("a.da",      1, 1, 1, 3'b010, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);
    cyc("a.lfd",     1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b010, 0, 0);
    cyc("a.ld1",     1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 0);
    cyc("a.ld2",     1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 0);
    cyc("a.ld3",     1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 0);
    cyc("a.ld4",     1, 0, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 1);
    cyc("a.lp",      1, 0, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_PARITY,        3'b010, 0, 1);
    cyc("a.cpe",     1, 0, 0, 3'b010, 0, 0, 0, 3'b000, CHECK_PARITY_ERROR, 3'b010, 0, 1);
    cyc("a.da2",     1, 0, 0, 3'b010, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b010, 0, 0);

    // Exactly three beats: len_err appears after the third write
    cyc("l.da",      1, 1, 2, 3'b100, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b010, 0, 0);
    cyc("l.lfd",     1, 1, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b100, 0, 0);
    cyc("l.ld1",     1, 1, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_DATA,          3'b100, 0, 0);
    cyc("l.ld2",     1, 1, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_DATA,          3'b100, 0, 0);
    cyc("l.ld3",     1, 0, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_DATA,          3'b100, 0, 0);
    cyc("l.lp",      1, 0, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_PARITY,        3'b100, 0, 1);
    cyc("l.cpe",     1, 0, 0, 3'b100, 0, 0, 0, 3'b000, CHECK_PARITY_ERROR, 3'b100, 0, 1);
    cyc("l.da2",     1, 0, 0, 3'b100, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b100, 0, 0);

    // Out-of-range address is dropped; soft resets are ignored with no channel selected
    cyc("b.da",      1, 1, 3, 3'b111, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b100, 0, 0);
    cyc("b.drop1",   1, 1, 0, 3'b111, 0, 0, 0, 3'b111, DROP_PACKET,        3'b000, 0, 0);
    cyc("b.drop2",   1, 1, 0, 3'b111, 0, 0, 0, 3'b000, DROP_PACKET,        3'b000, 0, 0);
    cyc("b.drop3",   1, 0, 0, 3'b111, 0, 0, 0, 3'b000, DROP_PACKET,        3'b000, 0, 0);
    cyc("b.da2",     1, 0, 0, 3'b111, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);

    // Wait timeout on the fourth WAIT cycle
    cyc("c.da",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);
    cyc("c.w1",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("c.w2",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("c.w3",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("c.w4",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 1, 0);
    cyc("c.drop1",   1, 1, 0, 3'b110, 0, 0, 0, 3'b000, DROP_PACKET,        3'b001, 0, 0);
    cyc("c.drop2",   1, 0, 0, 3'b110, 0, 0, 0, 3'b000, DROP_PACKET,        3'b001, 0, 0);
    cyc("c.da2",     1, 0, 0, 3'b110, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b001, 0, 0);

    // Empty arrives on the timeout cycle: empty wins
    cyc("e.da",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b001, 0, 0);
    cyc("e.w1",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("e.w2",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("e.w3",      1, 1, 0, 3'b110, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("e.w4",      1, 1, 0, 3'b111, 0, 0, 0, 3'b000, WAIT_TILL_EMPTY,    3'b001, 0, 0);
    cyc("e.lfd",     1, 1, 0, 3'b111, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b001, 0, 0);
    cyc("e.ld",      1, 0, 0, 3'b111, 0, 0, 0, 3'b000, LOAD_DATA,          3'b001, 0, 0);
    cyc("e.lp",      1, 0, 0, 3'b111, 0, 0, 0, 3'b000, LOAD_PARITY,        3'b001, 0, 0);
    cyc("e.cpe",     1, 0, 0, 3'b111, 0, 0, 0, 3'b000, CHECK_PARITY_ERROR, 3'b001, 0, 0);
    cyc("e.da2",     1, 0, 0, 3'b111, 0, 0, 0, 3'b001, DECODE_ADDRESS,     3'b001, 0, 0);
    cyc("e.da3",     1, 0, 0, 3'b111, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);

    // FIFO full excursions: FFS x3 -> LAF -> LD, then LAF with low_pkt_valid, CPE full, LAF parity_done
    cyc("d.da",      1, 1, 1, 3'b010, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);
    cyc("d.lfd",     1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b010, 0, 0);
    cyc("d.ld1",     1, 1, 0, 3'b010, 1, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 0);
    cyc("d.ffs1",    1, 1, 0, 3'b010, 1, 0, 0, 3'b000, FIFO_FULL_STATE,    3'b010, 0, 0);
    cyc("d.ffs2",    1, 1, 0, 3'b010, 1, 0, 0, 3'b000, FIFO_FULL_STATE,    3'b010, 0, 0);
    cyc("d.ffs3",    1, 1, 0, 3'b010, 0, 0, 0, 3'b000, FIFO_FULL_STATE,    3'b010, 0, 0);
    cyc("d.laf1",    1, 1, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_AFTER_FULL,    3'b010, 0, 0);
    cyc("d.ld2",     1, 1, 0, 3'b010, 1, 0, 0, 3'b000, LOAD_DATA,          3'b010, 0, 0);
    cyc("d.ffs4",    1, 0, 0, 3'b010, 0, 0, 0, 3'b000, FIFO_FULL_STATE,    3'b010, 0, 1);
    cyc("d.laf2",    1, 0, 0, 3'b010, 0, 0, 1, 3'b000, LOAD_AFTER_FULL,    3'b010, 0, 1);
    cyc("d.lp",      1, 0, 0, 3'b010, 0, 0, 0, 3'b000, LOAD_PARITY,        3'b010, 0, 1);
    cyc("d.cpe",     1, 0, 0, 3'b010, 1, 0, 0, 3'b000, CHECK_PARITY_ERROR, 3'b010, 0, 1);
    cyc("d.ffs5",    1, 0, 0, 3'b010, 0, 0, 0, 3'b000, FIFO_FULL_STATE,    3'b010, 0, 1);
    cyc("d.laf3",    1, 0, 0, 3'b010, 0, 1, 0, 3'b000, LOAD_AFTER_FULL,    3'b010, 0, 1);
    cyc("d.da2",     1, 0, 0, 3'b010, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b010, 0, 0);

    // Soft reset: other channel ignored, selected channel aborts the packet
    cyc("s.da",      1, 1, 0, 3'b001, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b010, 0, 0);
    cyc("s.lfd",     1, 1, 0, 3'b001, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b001, 0, 0);
    cyc("s.ld1",     1, 1, 0, 3'b001, 0, 0, 0, 3'b100, LOAD_DATA,          3'b001, 0, 0);
    cyc("s.ld2",     1, 1, 0, 3'b001, 0, 0, 0, 3'b001, LOAD_DATA,          3'b001, 0, 0);
    cyc("s.da2",     1, 0, 0, 3'b001, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);

    // Hard reset mid-packet
    cyc("r.da",      1, 1, 2, 3'b100, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);
    cyc("r.lfd",     1, 1, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_FIRST_DATA,    3'b100, 0, 0);
    cyc("r.ld",      0, 1, 0, 3'b100, 0, 0, 0, 3'b000, LOAD_DATA,          3'b100, 0, 0);
    cyc("r.da2",     1, 0, 0, 3'b100, 0, 0, 0, 3'b000, DECODE_ADDRESS,     3'b000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
